// File: rtl/spi_cmd_decoder_if.sv
// Bus bundle between the SPI command decoder and its neighbours.
//
// Purpose: groups the received-byte stream, the transmit-byte port and the
// valid/ready memory bus into one interface. The decoder uses the slave
// modport; the surrounding logic (SPI client plus memory) uses master.
//
// Signals:
//   i_rx_valid / i_rx_start / i_rx_data   received byte stream (start = first byte after CS)
//   o_tx_valid / o_tx_data / i_tx_ready   transmit byte port (ready = byte latched)
//   o_mem_valid / i_mem_ready             memory request handshake
//   o_mem_we / o_mem_addr / o_mem_wdata   memory request payload
//   i_mem_rvalid / i_mem_rdata            in-order read responses
//   o_err                                 sticky error flag
interface spi_cmd_decoder_if #(
    parameter int ADDR_BYTES = 2
);
    logic                    i_rx_valid;
    logic                    i_rx_start;
    logic [7:0]              i_rx_data;
    logic                    o_tx_valid;
    logic [7:0]              o_tx_data;
    logic                    i_tx_ready;
    logic                    o_mem_valid;
    logic                    i_mem_ready;
    logic                    o_mem_we;
    logic [8*ADDR_BYTES-1:0] o_mem_addr;
    logic [7:0]              o_mem_wdata;
    logic                    i_mem_rvalid;
    logic [7:0]              i_mem_rdata;
    logic                    o_err;

    // Decoder side.
    modport slave (
        input  i_rx_valid, i_rx_start, i_rx_data,
        output o_tx_valid, o_tx_data,
        input  i_tx_ready,
        output o_mem_valid,
        input  i_mem_ready,
        output o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rvalid, i_mem_rdata,
        output o_err
    );

    // Environment side (SPI client and memory).
    modport master (
        output i_rx_valid, i_rx_start, i_rx_data,
        input  o_tx_valid, o_tx_data,
        output i_tx_ready,
        input  o_mem_valid,
        output i_mem_ready,
        input  o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rvalid, i_mem_rdata,
        input  o_err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder.
//
// Purpose: turns each chip-select transaction from the SPI client into a
// write, read or status command. Writes and reads go out on a valid/ready
// memory bus; read data is prefetched into a small transmit FIFO so the
// SPI client always has a byte to shift out (FILLER when the FIFO is empty).
//
// Ports:
//   i_clock    system clock
//   i_reset_n  synchronous active-low reset
//   bus        spi_cmd_decoder_if.slave: rx stream, tx port, memory bus, o_err
module spi_cmd_decoder #(
    parameter int         ADDR_BYTES = 2,
    parameter int         TX_DEPTH   = 2,
    parameter logic [7:0] FILLER     = 8'h00
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    spi_cmd_decoder_if.slave bus
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_IGNORE
    } state_t;

    state_t        r_state;
    logic          r_is_read;
    logic [1:0]    r_addr_cnt;
    logic [AW-1:0] r_addr;         // running address pointer of the current command
    logic          r_req_own;      // pending request was issued by the current command
    logic          r_mem_valid;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_wdata;
    logic [1:0]    r_status;       // {overrun, bad_opcode}
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_fifo [TX_DEPTH];

    logic          w_byte;
    logic          w_op;
    logic          w_accept;
    logic          w_rd_acc;
    logic          w_rsp_discard;
    logic          w_rsp_keep;
    logic          w_pop;
    logic          w_push_rsp;
    logic          w_issue;
    logic [AW-1:0] w_ptr;
    logic [AW-1:0] w_addr_shift;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_abort_total;
    logic          w_fifo_we;
    logic [PW-1:0] w_fifo_waddr;
    logic [7:0]    w_fifo_wdata;

    assign w_byte        = bus.i_rx_valid && !bus.i_rx_start;
    assign w_op          = bus.i_rx_valid && bus.i_rx_start;
    assign w_accept      = r_mem_valid && bus.i_mem_ready;
    assign w_rd_acc      = w_accept && !r_mem_we;
    // Responses are in order: older (discarded) ones always come first.
    assign w_rsp_discard = bus.i_mem_rvalid && (r_discard != '0);
    assign w_rsp_keep    = bus.i_mem_rvalid && (r_discard == '0) && (r_outstanding != '0);
    assign w_pop         = bus.i_tx_ready && (r_count != '0);
    assign w_push_rsp    = w_rsp_keep && !w_op && ((r_count != DEPTH_C) || w_pop);

    // Write data arriving in the acceptance cycle must target the next address.
    assign w_ptr         = (w_accept && r_req_own) ? r_addr + AW'(1) : r_addr;
    assign w_addr_shift  = (r_addr << 8) | AW'(bus.i_rx_data);

    // Every byte that could still land in the FIFO counts, including discarded
    // responses, so the counters can never exceed TX_DEPTH.
    assign w_inflight    = r_count + r_outstanding + r_discard + CW'(r_mem_valid);
    assign w_issue       = (r_state == S_READ) && !w_op && !r_mem_valid && (w_inflight < DEPTH_C);

    // On an opcode, everything still owed by memory becomes discard; a read
    // accepted in this very cycle is included, a response in this cycle is consumed.
    assign w_abort_total = r_discard + r_outstanding + CW'(w_rd_acc)
                         - CW'(w_rsp_discard || w_rsp_keep);

    always_comb begin
        w_fifo_we    = 1'b0;
        w_fifo_waddr = r_wr_ptr;
        w_fifo_wdata = bus.i_mem_rdata;
        if (w_op) begin
            if (bus.i_rx_data == 8'h05) begin
                // FIFO is flushed in the same cycle, so the status byte goes to slot 0.
                w_fifo_we    = 1'b1;
                w_fifo_waddr = '0;
                w_fifo_wdata = {6'b0, r_status};
            end
        end else if (w_push_rsp) begin
            w_fifo_we = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_fifo_we) begin
            r_fifo[w_fifo_waddr] <= w_fifo_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_is_read     <= 1'b0;
            r_addr_cnt    <= '0;
            r_addr        <= '0;
            r_req_own     <= 1'b0;
            r_mem_valid   <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_status      <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_accept) begin
                r_mem_valid <= 1'b0;
            end
            if (w_accept && r_req_own) begin
                r_addr <= r_addr + AW'(1);
            end

            if (w_op) begin
                r_req_own     <= 1'b0;
                // A pending write is kept; an unaccepted read is withdrawn.
                if (r_mem_valid && !r_mem_we && !bus.i_mem_ready) begin
                    r_mem_valid <= 1'b0;
                end
                r_outstanding <= '0;
                r_discard     <= w_abort_total;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_count       <= '0;
                r_addr_cnt    <= '0;
                case (bus.i_rx_data)
                    8'h02: begin
                        r_is_read <= 1'b0;
                        r_state   <= S_ADDR;
                    end
                    8'h03: begin
                        r_is_read <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                    8'h05: begin
                        r_status <= '0;
                        r_wr_ptr <= PW'(1);
                        r_count  <= CW'(1);
                        r_state  <= S_IGNORE;
                    end
                    default: begin
                        r_status[0] <= 1'b1;
                        r_state     <= S_IGNORE;
                    end
                endcase
            end else begin
                r_outstanding <= r_outstanding + CW'(w_rd_acc) - CW'(w_rsp_keep);
                r_discard     <= r_discard - CW'(w_rsp_discard);
                if (w_push_rsp) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_push_rsp) - CW'(w_pop);

                case (r_state)
                    S_ADDR: begin
                        if (w_byte) begin
                            r_addr <= w_addr_shift;
                            if (r_addr_cnt == 2'(ADDR_BYTES - 1)) begin
                                r_state <= r_is_read ? S_READ : S_WRITE;
                            end else begin
                                r_addr_cnt <= r_addr_cnt + 2'd1;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (w_byte) begin
                            if (r_mem_valid && !bus.i_mem_ready) begin
                                r_status[1] <= 1'b1;
                            end else begin
                                r_mem_valid <= 1'b1;
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= w_ptr;
                                r_mem_wdata <= bus.i_rx_data;
                                r_req_own   <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        if (w_issue) begin
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= r_addr;
                            r_req_own   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.o_tx_valid  = 1'b1;
    assign bus.o_tx_data   = (r_count != '0) ? r_fifo[r_rd_ptr] : FILLER;
    assign bus.o_mem_valid = r_mem_valid;
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_err       = |r_status;
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder (ADDR_BYTES=2, TX_DEPTH=2, FILLER=0).
// Memory requests are checked against a queue of expected requests filled as
// stimulus is driven; a small memory model answers reads with addr[7:0]+1.
module tb_spi_cmd_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_decoder_if #(.ADDR_BYTES(2)) bus ();

    spi_cmd_decoder #(
        .ADDR_BYTES(2),
        .TX_DEPTH  (2),
        .FILLER    (8'h00)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rsp_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] follow;
        logic       exp_err;
        logic [7:0] exp_stat;
    } op_vec_t;

    req_t exp_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rsp_lat = 2;
    int   n_rd_acc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic start);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_start = start;
        bus.i_rx_data  = data;
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_start = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check(name, 32'(bus.o_tx_data), 32'(exp));
        bus.i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_tx_ready = 1'b0;
    endtask

    task automatic expect_req(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        req_t r;
        r.we = we;
        r.addr = addr;
        r.wdata = wdata;
        exp_q.push_back(r);
    endtask

    // Request monitor: inputs only change just after posedge, so the values
    // seen at negedge are those the next posedge will accept.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_mem_valid && bus.i_mem_ready) begin
                $display("mem req we=%0b addr=%h wdata=%h", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
                if (exp_q.size() == 0) begin
                    check("unexpected_req_addr", 32'(bus.o_mem_addr), 32'hFFFF_FFFF);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("req_we", 32'(bus.o_mem_we), 32'(e.we));
                    check("req_addr", 32'(bus.o_mem_addr), 32'(e.addr));
                    if (e.we) begin
                        check("req_wdata", 32'(bus.o_mem_wdata), 32'(e.wdata));
                    end
                end
                if (!bus.o_mem_we) begin
                    rsp_t r;
                    r.data = bus.o_mem_addr[7:0] + 8'd1;
                    r.due = cyc + rsp_lat;
                    rsp_q.push_back(r);
                    n_rd_acc++;
                end
            end
        end
    end

    // Memory read-response model.
    initial begin
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                bus.i_mem_rvalid = 1'b1;
                bus.i_mem_rdata  = rsp_q[0].data;
                void'(rsp_q.pop_front());
            end else begin
                bus.i_mem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        op_vec_t vecs[4];
        int base;

        vecs[0] = '{8'h7F, 8'h01, 1'b1, 8'h01};
        vecs[1] = '{8'h00, 8'h02, 1'b1, 8'h01};
        vecs[2] = '{8'h05, 8'hAA, 1'b0, 8'h00};
        vecs[3] = '{8'h01, 8'h03, 1'b1, 8'h01};

        bus.i_rx_valid  = 1'b0;
        bus.i_rx_start  = 1'b0;
        bus.i_rx_data   = 8'h00;
        bus.i_tx_ready  = 1'b0;
        bus.i_mem_ready = 1'b1;

        // Reset state.
        idle(3);
        check("rst_tx_valid", 32'(bus.o_tx_valid), 32'd1);
        check("rst_tx_data", 32'(bus.o_tx_data), 32'h00);
        check("rst_mem_valid", 32'(bus.o_mem_valid), 32'd0);
        check("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.o_mem_wdata), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Write burst, second data byte arrives in the acceptance cycle.
        expect_req(1'b1, 16'h1234, 8'hAA);
        expect_req(1'b1, 16'h1235, 8'hBB);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        idle(5);
        check("wr_err", 32'(bus.o_err), 32'd0);
        check("wr_idle_valid", 32'(bus.o_mem_valid), 32'd0);

        // Read prefetch with 2-cycle memory latency.
        expect_req(1'b0, 16'h0010, 8'h00);
        expect_req(1'b0, 16'h0011, 8'h00);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        idle(12);
        expect_req(1'b0, 16'h0012, 8'h00);
        pop_check("rd_pop0", 8'h11);
        expect_req(1'b0, 16'h0013, 8'h00);
        pop_check("rd_pop1", 8'h12);
        idle(12);
        check("rd_head_refill", 32'(bus.o_tx_data), 32'h13);

        // Overrun: second data byte arrives while the first is stalled.
        bus.i_mem_ready = 1'b0;
        expect_req(1'b1, 16'h0020, 8'hC1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        idle(20);
        bus.i_mem_ready = 1'b1;
        idle(3);
        check("ovr_err", 32'(bus.o_err), 32'd1);
        send_byte(8'h05, 1'b1);
        idle(1);
        pop_check("ovr_status", 8'h02);
        check("ovr_err_cleared", 32'(bus.o_err), 32'd0);
        send_byte(8'h05, 1'b1);
        idle(1);
        pop_check("ovr_status_again", 8'h00);

        // Opcode table: no memory activity expected from any of these.
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].op, 1'b1);
            send_byte(vecs[i].follow, 1'b0);
            idle(2);
            check($sformatf("op%0d_err", i), 32'(bus.o_err), 32'(vecs[i].exp_err));
            send_byte(8'h05, 1'b1);
            idle(1);
            pop_check($sformatf("op%0d_status", i), vecs[i].exp_stat);
            check($sformatf("op%0d_err_after", i), 32'(bus.o_err), 32'd0);
        end

        // Abort a read with two responses outstanding.
        send_byte(8'h7F, 1'b1);
        rsp_lat = 10;
        base = n_rd_acc;
        expect_req(1'b0, 16'h0040, 8'h00);
        expect_req(1'b0, 16'h0041, 8'h00);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h40, 1'b0);
        for (int k = 0; k < 50 && (n_rd_acc - base) < 2; k++) begin
            idle(1);
        end
        check("abort_rd_issued", 32'(n_rd_acc - base), 32'd2);
        send_byte(8'h05, 1'b1);
        idle(15);
        pop_check("abort_status_head", 8'h01);
        idle(1);
        check("abort_filler", 32'(bus.o_tx_data), 32'h00);
        rsp_lat = 2;

        // Reset in the middle of a stalled write.
        bus.i_mem_ready = 1'b0;
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        idle(2);
        check("pre_rst_valid", 32'(bus.o_mem_valid), 32'd1);
        check("pre_rst_err", 32'(bus.o_err), 32'd1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("post_rst_valid", 32'(bus.o_mem_valid), 32'd0);
        check("post_rst_tx", 32'(bus.o_tx_data), 32'h00);
        check("post_rst_err", 32'(bus.o_err), 32'd0);
        bus.i_mem_ready = 1'b1;
        idle(4);

        check("req_queue_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
